// File: rtl/wb_write_queue_pkg.sv
// Shared CPU-level constants and small helpers for the write-back queue.
package wb_write_queue_pkg;

  // Default data width and register-file address width of the CPU.
  localparam int XLEN_DEF   = 32;
  localparam int REG_ADDR_W = 5;

  // Source selected for the register-file write register in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_FIFO = 2'd1,
    SRC_ALU  = 2'd2,
    SRC_MEM  = 2'd3
  } wb_src_e;

  // x0 is hardwired to zero: writes to it are dropped and it never matches a query.
  function automatic logic addr_is_live(input logic [REG_ADDR_W-1:0] addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Dual-push, single-pop circular buffer of pending register writes.
// Every entry's address, data and valid bit is visible so the owner can
// search pending writes. push1 is only used together with push0, and push0
// is always the older of the two.
module wb_fifo
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEF,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                push0_valid,
  input  logic [REG_ADDR_W-1:0]               push0_addr,
  input  logic [XLEN-1:0]                     push0_data,
  input  logic                                push1_valid,
  input  logic [REG_ADDR_W-1:0]               push1_addr,
  input  logic [XLEN-1:0]                     push1_data,
  input  logic                                pop,
  output logic [CNT_W-1:0]                    count,
  output logic [PTR_W-1:0]                    rd_ptr,
  output logic [DEPTH-1:0]                    ent_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    ent_addr,
  output logic [DEPTH-1:0][XLEN-1:0]          ent_data
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_1;
  logic [DEPTH-1:0] valid_next;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign wr_ptr_1 = ptr_inc(wr_ptr);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push1_valid)      wr_ptr <= ptr_inc(wr_ptr_1);
      else if (push0_valid) wr_ptr <= wr_ptr_1;
      count <= count + CNT_W'(push0_valid) + CNT_W'(push1_valid) - CNT_W'(pop);
    end
  end

  // Next valid bits: the pop clears first so that a push into the slot being
  // drained in the same cycle (full queue) leaves it valid.
  always_comb begin
    valid_next = ent_valid;
    if (pop)         valid_next[rd_ptr]   = 1'b0;
    if (push0_valid) valid_next[wr_ptr]   = 1'b1;
    if (push1_valid) valid_next[wr_ptr_1] = 1'b1;
  end

  // Valid bits are reset so no stale entry can ever produce a query hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ent_valid <= '0;
    else        ent_valid <= valid_next;
  end

  // Payload storage; contents are only meaningful where ent_valid is set.
  always_ff @(posedge clk) begin
    if (push0_valid) begin
      ent_addr[wr_ptr] <= push0_addr;
      ent_data[wr_ptr] <= push0_data;
    end
    if (push1_valid) begin
      ent_addr[wr_ptr_1] <= push1_addr;
      ent_data[wr_ptr_1] <= push1_data;
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// Write-back arbiter: merges ALU and load results into a single registered
// register-file write port, buffering overflow in a small FIFO, and answers
// ID-stage queries about writes that are still pending in that FIFO.
//
// Handshake: the ALU path has no ready; every alu_valid cycle is a transfer.
// The load path transfers on a cycle where mem_valid && mem_ready; mem_ready
// depends only on registered occupancy, never on mem_valid, so the producer
// may hold mem_valid and its payload stable until it sees the transfer.
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEF,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic [XLEN-1:0]       mem_data,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] WriteAddr,
  output logic [XLEN-1:0]       WriteData,
  input  logic [REG_ADDR_W-1:0] q_rs1_addr,
  input  logic [REG_ADDR_W-1:0] q_rs2_addr,
  output logic                  q_rs1_hit,
  output logic                  q_rs2_hit,
  output logic [XLEN-1:0]       q_rs1_data,
  output logic [XLEN-1:0]       q_rs2_data
);

  logic [CNT_W-1:0]                 count;
  logic [PTR_W-1:0]                 rd_ptr;
  logic [DEPTH-1:0]                 ent_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][XLEN-1:0]       ent_data;

  logic                  alu_take;
  logic                  mem_take;
  wb_src_e               src;
  logic                  load_valid;
  logic [REG_ADDR_W-1:0] load_addr;
  logic [XLEN-1:0]       load_data;
  logic                  pop;
  logic                  push0_valid;
  logic [REG_ADDR_W-1:0] push0_addr;
  logic [XLEN-1:0]       push0_data;
  logic                  push1_valid;
  logic [REG_ADDR_W-1:0] push1_addr;
  logic [XLEN-1:0]       push1_data;
  logic [PTR_W-1:0]      q_slot;

  // A full FIFO still accepts an ALU result because the head always drains
  // in the same cycle; only the load path is throttled.
  assign mem_ready = (count <= CNT_W'(DEPTH - 1));

  // Accepted entries that actually need storing (x0 writes are dropped).
  assign alu_take = alu_valid && addr_is_live(alu_addr);
  assign mem_take = mem_valid && mem_ready && addr_is_live(mem_addr);

  // Oldest-first slot of the entry that is ofs positions behind the head.
  function automatic logic [PTR_W-1:0] age_slot(input logic [PTR_W-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  // Pick the write-port source (FIFO head first, then ALU, then MEM) and
  // enqueue whatever was accepted but not chosen, ALU ahead of MEM.
  always_comb begin
    src         = SRC_NONE;
    load_valid  = 1'b0;
    load_addr   = '0;
    load_data   = '0;
    pop         = 1'b0;
    push0_valid = 1'b0;
    push0_addr  = '0;
    push0_data  = '0;
    push1_valid = 1'b0;
    push1_addr  = '0;
    push1_data  = '0;

    if (count != '0)   src = SRC_FIFO;
    else if (alu_take) src = SRC_ALU;
    else if (mem_take) src = SRC_MEM;

    case (src)
      SRC_FIFO: begin
        pop        = 1'b1;
        load_valid = 1'b1;
        load_addr  = ent_addr[rd_ptr];
        load_data  = ent_data[rd_ptr];
        if (alu_take) begin
          push0_valid = 1'b1;
          push0_addr  = alu_addr;
          push0_data  = alu_data;
          if (mem_take) begin
            push1_valid = 1'b1;
            push1_addr  = mem_addr;
            push1_data  = mem_data;
          end
        end else if (mem_take) begin
          push0_valid = 1'b1;
          push0_addr  = mem_addr;
          push0_data  = mem_data;
        end
      end
      SRC_ALU: begin
        load_valid = 1'b1;
        load_addr  = alu_addr;
        load_data  = alu_data;
        if (mem_take) begin
          push0_valid = 1'b1;
          push0_addr  = mem_addr;
          push0_data  = mem_data;
        end
      end
      SRC_MEM: begin
        load_valid = 1'b1;
        load_addr  = mem_addr;
        load_data  = mem_data;
      end
      default: ;
    endcase
  end

  // Registered register-file write port; RegWrite marks a freshly loaded entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite  <= 1'b0;
      WriteAddr <= '0;
      WriteData <= '0;
    end else begin
      RegWrite <= load_valid;
      if (load_valid) begin
        WriteAddr <= load_addr;
        WriteData <= load_data;
      end
    end
  end

  // Pending-write query over FIFO entries only, scanned oldest to youngest
  // so the youngest match wins. The output register is left to the
  // register-file bypass, and this cycle's incoming pushes are not visible.
  always_comb begin
    q_slot     = '0;
    q_rs1_hit  = 1'b0;
    q_rs1_data = '0;
    q_rs2_hit  = 1'b0;
    q_rs2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      q_slot = age_slot(rd_ptr, i);
      if (ent_valid[q_slot] && addr_is_live(q_rs1_addr) && ent_addr[q_slot] == q_rs1_addr) begin
        q_rs1_hit  = 1'b1;
        q_rs1_data = ent_data[q_slot];
      end
      if (ent_valid[q_slot] && addr_is_live(q_rs2_addr) && ent_addr[q_slot] == q_rs2_addr) begin
        q_rs2_hit  = 1'b1;
        q_rs2_data = ent_data[q_slot];
      end
    end
  end

  wb_fifo #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push0_valid (push0_valid),
    .push0_addr  (push0_addr),
    .push0_data  (push0_data),
    .push1_valid (push1_valid),
    .push1_addr  (push1_addr),
    .push1_data  (push1_data),
    .pop         (pop),
    .count       (count),
    .rd_ptr      (rd_ptr),
    .ent_valid   (ent_valid),
    .ent_addr    (ent_addr),
    .ent_data    (ent_data)
  );

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue with a write scoreboard.
module tb_wb_write_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int W     = 5 + XLEN;

  logic            clk;
  logic            rst_n;
  logic            alu_valid;
  logic [4:0]      alu_addr;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [4:0]      mem_addr;
  logic [XLEN-1:0] mem_data;
  logic            RegWrite;
  logic [4:0]      WriteAddr;
  logic [XLEN-1:0] WriteData;
  logic [4:0]      q_rs1_addr;
  logic [4:0]      q_rs2_addr;
  logic            q_rs1_hit;
  logic            q_rs2_hit;
  logic [XLEN-1:0] q_rs1_data;
  logic [XLEN-1:0] q_rs2_data;

  logic [W-1:0] exp_q[$];
  int checks;
  int errors;
  int model_cnt;

  wb_write_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .RegWrite   (RegWrite),
    .WriteAddr  (WriteAddr),
    .WriteData  (WriteData),
    .q_rs1_addr (q_rs1_addr),
    .q_rs2_addr (q_rs2_addr),
    .q_rs1_hit  (q_rs1_hit),
    .q_rs2_hit  (q_rs2_hit),
    .q_rs1_data (q_rs1_data),
    .q_rs2_data (q_rs2_data)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every register-file write must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && RegWrite) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got x%0d=0x%0h required no write", WriteAddr, WriteData);
      end else begin
        check("write", 64'({WriteAddr, WriteData}), 64'(exp_q.pop_front()));
      end
    end
  end

  // Driver: present one cycle of inputs, check mem_ready against the model
  // occupancy and record what the DUT must eventually write.
  task automatic apply(input logic av, input logic [4:0] aa, input logic [XLEN-1:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [XLEN-1:0] md,
                       output logic macc);
    int pushes;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    #1;
    check("mem_ready", 64'(mem_ready), 64'(model_cnt <= DEPTH - 1));
    macc   = mv && (model_cnt <= DEPTH - 1);
    pushes = 0;
    if (av && aa != 5'd0) begin exp_q.push_back({aa, ad}); pushes++; end
    if (macc && ma != 5'd0) begin exp_q.push_back({ma, md}); pushes++; end
    if (model_cnt > 0 || pushes > 0) model_cnt = model_cnt + pushes - 1;
    if (model_cnt > DEPTH) begin
      checks++;
      errors++;
      $display("FAIL model_overflow: got %0d required <= %0d", model_cnt, DEPTH);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic macc;
    for (int k = 0; k < n; k++) begin
      apply(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, macc);
      step();
    end
  endtask

  initial begin
    logic macc;
    logic pending;
    checks = 0; errors = 0; model_cnt = 0;
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    q_rs1_addr = '0; q_rs2_addr = '0;

    // Reset state
    #2;
    check("rst_regwrite", 64'(RegWrite), 64'd0);
    check("rst_waddr", 64'(WriteAddr), 64'd0);
    check("rst_wdata", 64'(WriteData), 64'd0);
    check("rst_mem_ready", 64'(mem_ready), 64'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Single ALU write, one-cycle latency
    apply(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, '0, macc);
    step();
    check("lat_regwrite", 64'(RegWrite), 64'd1);
    check("lat_waddr", 64'(WriteAddr), 64'd5);
    check("lat_wdata", 64'(WriteData), 64'h11);
    idle(1);
    check("lat_regwrite_off", 64'(RegWrite), 64'd0);
    idle(2);

    // Same-cycle ALU + MEM; MEM entry visible to the query only afterwards
    q_rs1_addr = 5'd4;
    apply(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, macc);
    check("q_same_cycle_hit", 64'(q_rs1_hit), 64'd0);
    step();
    check("q_x4_hit", 64'(q_rs1_hit), 64'd1);
    check("q_x4_data", 64'(q_rs1_data), 64'hB);
    idle(1);
    check("q_x4_gone", 64'(q_rs1_hit), 64'd0);
    q_rs1_addr = '0;
    idle(2);

    // Both pushes for five cycles; hold the refused load until accepted
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 5'(10 + i), 32'(32'hA0 + i), 1'b1, 5'(20 + i), 32'(32'hB0 + i), macc);
      step();
    end
    pending = !macc;
    check("full_refused", 64'(pending), 64'd1);
    for (int k = 0; k < 10 && pending; k++) begin
      apply(1'b0, 5'd0, '0, 1'b1, 5'd24, 32'hB4, macc);
      step();
      pending = !macc;
    end
    check("full_retry_done", 64'(pending), 64'd0);
    idle(8);

    // Two queued writes to x7: youngest wins; x0 and drained entries never hit
    apply(1'b1, 5'd8, 32'h8, 1'b1, 5'd9, 32'h9, macc);
    step();
    apply(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, macc);
    step();
    q_rs1_addr = 5'd7; q_rs2_addr = 5'd9;
    apply(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, macc);
    check("q_x7_hit", 64'(q_rs1_hit), 64'd1);
    check("q_x7_young", 64'(q_rs1_data), 64'h2);
    check("q_outreg_hit", 64'(q_rs2_hit), 64'd0);
    check("q_nohit_data", 64'(q_rs2_data), 64'd0);
    step();
    q_rs2_addr = 5'd0;
    apply(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, macc);
    check("q_x7_still", 64'(q_rs1_data), 64'h2);
    check("q_x0_hit", 64'(q_rs2_hit), 64'd0);
    step();
    q_rs1_addr = '0;
    idle(3);

    // Write to x0 is swallowed
    apply(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, '0, macc);
    step();
    check("x0_regwrite", 64'(RegWrite), 64'd0);
    idle(2);

    // Reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 5'(1 + i), 32'(32'hC0 + i), 1'b1, 5'(11 + i), 32'(32'hD0 + i), macc);
      step();
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    q_rs1_addr = 5'd13;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_regwrite", 64'(RegWrite), 64'd0);
    check("mid_rst_waddr", 64'(WriteAddr), 64'd0);
    check("mid_rst_mem_ready", 64'(mem_ready), 64'd1);
    check("mid_rst_q_hit", 64'(q_rs1_hit), 64'd0);
    exp_q.delete();
    model_cnt = 0;
    q_rs1_addr = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(5);
    check("post_rst_mem_ready", 64'(mem_ready), 64'd1);

    // Queue still works after reset
    apply(1'b0, 5'd0, '0, 1'b1, 5'd6, 32'h66, macc);
    step();
    check("post_rst_regwrite", 64'(RegWrite), 64'd1);
    idle(2);

    // Drain: every expected write must have appeared
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) @(posedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_write_queue.md
WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of FIFO entries behind the write-port output register.
REQ-002 SHALL have parameter XLEN, default 32, meaning the data width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 alu_valid  input  1  ALU result present; the ALU path is never back-pressured.
REQ-006 alu_addr / alu_data  input  5 / XLEN  ALU destination register and value.
REQ-007 mem_valid  input  1  load result present.
REQ-008 mem_ready  output  1  load result accepted when mem_valid && mem_ready.
REQ-009 mem_addr / mem_data  input  5 / XLEN  load destination register and value.
REQ-010 RegWrite  output  1  register-file write enable, registered.
REQ-011 WriteAddr / WriteData  output  5 / XLEN  register-file write address and data, registered.
REQ-012 q_rs1_addr / q_rs2_addr  input  5  ID-stage source addresses for the pending-write query.
REQ-013 q_rs1_hit / q_rs2_hit  output  1  a FIFO entry targets that address.
REQ-014 q_rs1_data / q_rs2_data  output  XLEN  data of the youngest matching FIFO entry; 0 when there is no hit.

Function
REQ-015 A push with address 0 SHALL be accepted and discarded: it is never enqueued and never written.
REQ-016 Each cycle the output register SHALL load from the first available source: FIFO head, then accepted ALU entry, then accepted MEM entry.
REQ-017 Remaining accepted entries SHALL enqueue in ALU-then-MEM order.
REQ-018 RegWrite SHALL be 1 in a cycle exactly when an entry was loaded into the output register at the preceding edge; otherwise it is 0.
REQ-019 Latency from accepting edge to RegWrite high with an empty FIFO SHALL be 1 cycle.
REQ-020 Register-file writes SHALL occur in acceptance order, with ALU ahead of MEM within one cycle.
REQ-021 count' SHALL equal count + pushes - (1 if the output register was loaded), where pushes excludes address-0 entries.
REQ-022 mem_ready SHALL equal (count <= DEPTH-1), is combinational from registered count only, and count SHALL never exceed DEPTH.
REQ-023 An ALU push with count == DEPTH SHALL still be accepted, since the head drains in the same cycle.
REQ-024 Simultaneous pop and two pushes SHALL be legal at any count < DEPTH.
REQ-025 The query SHALL be combinational over FIFO entries only; the output register is covered by register-file bypass.
REQ-026 Same-cycle incoming pushes SHALL be excluded from the query.
REQ-027 Address 0 SHALL never produce a query hit.
REQ-028 When several FIFO entries match, the query SHALL return the youngest.
REQ-029 Read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 rst_n low SHALL immediately set count=0, pointers=0, RegWrite=0, WriteAddr=0, WriteData=0, and deassert all query hits.
REQ-031 Reset mid-operation SHALL drop all queued entries without any register-file write.
REQ-032 mem_ready SHALL be 1 during and after reset.

Structure
REQ-033 XLEN and REG_ADDR_W=5 SHALL come from the shared CPU defines include.
REQ-034 Storage SHALL be one sub-module, wb_fifo (dual-push, single-pop, with per-entry address/valid visible for the query); arbitration, output register and query logic stay in wb_write_queue.

Verification
REQ-035 Reset, then ALU push x5=0x11 -> next cycle RegWrite=1, WriteAddr=5, WriteData=0x11; following cycle RegWrite=0.
REQ-036 Same-cycle ALU x3=0xA and MEM x4=0xB, FIFO empty -> x3 written in cycle 1 and x4 in cycle 2; q_rs1_addr=4 gives hit=1, data=0xB during cycle 1.
REQ-037 Both pushes every cycle for 5 cycles -> mem_ready falls when count reaches 4; no entry lost; writes appear in ALU/MEM alternating order; count never exceeds 4.
REQ-038 Two queued writes to x7 (0x1 then 0x2) -> query x7 returns 0x2; query x0 returns hit=0.
REQ-039 ALU push to x0 -> no RegWrite, count unchanged.
REQ-040 rst_n pulsed low with 3 entries queued -> RegWrite=0 immediately, no writes after release, mem_ready=1.
